// File: rtl/dct_block_sequencer.sv
// rtl/dct_block_sequencer.sv - collects 8-sample blocks, runs the 8-point DCT core, serializes its coefficients
// Optional macro DCT_PINGPONG_EN: a second input buffer keeps filling while the active block is in flight.
module dct_block_sequencer #(
  parameter int DCT_LATENCY = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  input  logic             flush,
  output logic [63:0]      dct_in,
  output logic             dct_en,
  output logic             dct_cs,
  input  logic [95:0]      dct_coef,
  output logic             m_valid,
  output logic [11:0]      m_data,
  output logic [2:0]       m_index,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic [CNT_W-1:0] block_cnt
);

`ifdef DCT_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  localparam int WW = (DCT_LATENCY > 1) ? $clog2(DCT_LATENCY) : 1;

  typedef enum logic [1:0] {FILL, LAUNCH, WAIT, DRAIN} state_t;
  state_t state, state_nxt;

  logic [63:0]   bufq [2];
  logic          fsel, asel, pend;
  logic [2:0]    fcnt, idx;
  logic [WW-1:0] wcnt;
  logic [95:0]   coef;

  logic          fill_open, xfer, close, m_fire, last_fire, take;
  logic [3:0]    fcnt_inc;

  // take: the filling buffer (or the pending closed one) becomes the active block next cycle
  always_comb begin
    fill_open = PP ? !pend : (state == FILL);
    xfer      = s_valid && fill_open && !rst;
    fcnt_inc  = {1'b0, fcnt} + {3'b000, xfer};
    close     = fill_open && ((xfer && fcnt == 3'd7) || (flush && fcnt_inc != 4'd0));
    m_fire    = (state == DRAIN) && m_ready;
    last_fire = m_fire && (idx == 3'd7);
    take      = ((state == FILL) && close) || (last_fire && (pend || close));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (close) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (wcnt == '0) state_nxt = DRAIN;
      DRAIN:   if (last_fire) state_nxt = (pend || close) ? LAUNCH : FILL;
      default: state_nxt = FILL;
    endcase
  end

  // A drained buffer is cleared so later partial fills are already zero padded
  always_ff @(posedge clk) begin
    if (rst) begin
      bufq[0]   <= '0;
      bufq[1]   <= '0;
      fsel      <= 1'b0;
      asel      <= 1'b0;
      pend      <= 1'b0;
      fcnt      <= '0;
      idx       <= '0;
      wcnt      <= '0;
      coef      <= '0;
      block_cnt <= '0;
    end else begin
      if (last_fire) bufq[asel] <= '0;
      if (xfer) begin
        bufq[fsel][{fcnt, 3'b000} +: 8] <= s_data;
        fcnt <= fcnt + 3'd1;
      end
      if (take) begin
        asel <= fsel;
        fsel <= PP ? ~fsel : fsel;
        fcnt <= '0;
        pend <= 1'b0;
      end else if (close) begin
        pend <= 1'b1;
        fcnt <= '0;
      end
      if (state == LAUNCH) wcnt <= WW'(DCT_LATENCY - 1);
      else if (state == WAIT && wcnt != '0) wcnt <= wcnt - WW'(1);
      if (state == WAIT && wcnt == '0) coef <= dct_coef;
      if (m_fire) idx <= idx + 3'd1;
      if (last_fire) block_cnt <= block_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    s_ready = fill_open && !rst;
    dct_en  = (state == LAUNCH) || (state == WAIT);
    dct_cs  = dct_en;
    dct_in  = bufq[asel];
    m_valid = (state == DRAIN);
    m_data  = m_valid ? coef[int'(idx) * 12 +: 12] : '0;
    m_index = m_valid ? idx : '0;
    m_last  = m_valid && (idx == 3'd7);
    busy    = (state != FILL) || (fcnt != 3'd0);
  end

endmodule

// File: tb/tb_dct_block_sequencer.sv
// tb/tb_dct_block_sequencer.sv - directed and randomized bench with a core model and a block-level scoreboard
module tb_dct_block_sequencer;
  localparam int D = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, s_valid = 1'b0, flush = 1'b0, m_ready = 1'b0;
  logic [7:0]  s_data = '0;
  logic [95:0] dct_coef = '0;
  logic        s_ready, dct_en, dct_cs, m_valid, m_last, busy;
  logic [63:0] dct_in;
  logic [11:0] m_data;
  logic [2:0]  m_index;
  logic [15:0] block_cnt;
  logic        w_s_ready, w_dct_en, w_dct_cs, w_m_valid, w_m_last, w_busy;
  logic [63:0] w_dct_in;
  logic [11:0] w_m_data;
  logic [2:0]  w_m_index;
  logic [1:0]  w_block_cnt;

  dct_block_sequencer #(.DCT_LATENCY(D), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .flush(flush),
    .dct_in(dct_in), .dct_en(dct_en), .dct_cs(dct_cs), .dct_coef(dct_coef),
    .m_valid(m_valid), .m_data(m_data), .m_index(m_index), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .block_cnt(block_cnt));

  // narrow counter copy, driven identically, to exercise wrap-around
  dct_block_sequencer #(.DCT_LATENCY(D), .CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(w_s_ready), .flush(flush),
    .dct_in(w_dct_in), .dct_en(w_dct_en), .dct_cs(w_dct_cs), .dct_coef(dct_coef),
    .m_valid(w_m_valid), .m_data(w_m_data), .m_index(w_m_index), .m_last(w_m_last), .m_ready(m_ready),
    .busy(w_busy), .block_cnt(w_block_cnt));

  bit mode = 1'b0;
  int en_run = 0;

  function automatic logic [95:0] core_f(input logic [63:0] x, input bit md);
    logic [95:0] z;
    logic signed [11:0] s;
    z = '0;
    for (int i = 0; i < 8; i++) begin
      s = {{4{x[8*i+7]}}, x[8*i +: 8]};
      z[12*i +: 12] = md ? (s <<< 3) + 12'(i) : 12'(10 * i);
    end
    return z;
  endfunction

  // core: result valid only in the cycle DCT_LATENCY after the launch cycle, noise otherwise
  always @(posedge clk) en_run <= dct_en ? en_run + 1 : 0;
  always @(negedge clk)
    dct_coef <= (dct_en && en_run == D) ? core_f(dct_in, mode) : {$urandom, $urandom, $urandom};

  int tests = 0, fails = 0, cyc = 0;
  logic [7:0]  fillq[$];
  logic [11:0] expq[$];
  bit          pp = 1'b0, busy_m = 1'b0, pend_m = 1'b0, mv_prev = 1'b0, hold_v = 1'b0, last_sready = 1'b0;
  logic [63:0] pend_blk = '0;
  logic [11:0] hold_d = '0;
  logic [2:0]  hold_i = '0;
  int midx_m = 0, blocks = 0, launches = 0, en_cycles = 0, t_close = 0, mv0_cyc = 0, acc_busy = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [63:0] blk);
    logic [95:0] z;
    z = core_f(blk, mode);
    busy_m = 1'b1;
    launches++;
    for (int i = 0; i < 8; i++) expq.push_back(z[12*i +: 12]);
  endtask

  task automatic close_blk();
    logic [63:0] blk;
    blk = '0;
    for (int i = 0; i < fillq.size(); i++) blk[8*i +: 8] = fillq[i];
    fillq.delete();
    t_close = cyc;
    if (!busy_m) launch(blk);
    else begin
      pend_m = 1'b1;
      pend_blk = blk;
    end
  endtask

  task automatic tick(input bit sv, input logic [7:0] sd, input bit fl, input bit mr, input bit r);
    bit open;
    logic [11:0] e;
    @(negedge clk);
    s_valid = sv; s_data = sd; flush = fl; m_ready = mr; rst = r;
    #1;
    cyc++;
    open = !r && (pp ? !(busy_m && pend_m) : !busy_m);
    last_sready = s_ready;
    chk("s_ready", 96'(s_ready), 96'(open));
    if (dct_en) en_cycles++;
    if (hold_v && !r) begin
      chk("hold_data", 96'(m_data), 96'(hold_d));
      chk("hold_index", 96'(m_index), 96'(hold_i));
    end
    if (m_valid && !mv_prev) mv0_cyc = cyc;
    mv_prev = m_valid;
    hold_v = m_valid && !mr;
    hold_d = m_data;
    hold_i = m_index;
    if (sv && s_ready && (m_valid || dct_en)) acc_busy++;
    if (r) begin
      fillq.delete(); expq.delete();
      busy_m = 0; pend_m = 0; midx_m = 0; blocks = 0; launches = 0; en_cycles = 0;
      hold_v = 0; mv_prev = 0;
      return;
    end
    if (m_valid && mr) begin
      if (expq.size() == 0) chk("spurious_m_valid", 96'(m_valid), 96'(0));
      else begin
        e = expq.pop_front();
        chk("m_data", 96'(m_data), 96'(e));
        chk("m_index", 96'(m_index), 96'(midx_m));
        chk("m_last", 96'(m_last), 96'(midx_m == 7));
        if (midx_m == 7) begin
          midx_m = 0; busy_m = 0; blocks++;
          if (pend_m) begin
            pend_m = 0;
            launch(pend_blk);
          end
        end else midx_m++;
      end
    end
    if (sv && s_ready) begin
      fillq.push_back(sd);
      if (fillq.size() == 8) close_blk();
    end
    if (fl && open && fillq.size() > 0) close_blk();
  endtask

  task automatic drain_all();
    int k;
    k = 0;
    while ((busy_m || pend_m || expq.size() > 0) && k < 300) begin
      tick(0, 8'h00, 0, 1, 0);
      k++;
    end
    chk("drain_in_time", 96'(k < 300), 96'(1));
    tick(0, 8'h00, 0, 1, 0);
    chk("en_cycles", 96'(en_cycles), 96'(launches * (1 + D)));
    chk("block_cnt", 96'(block_cnt), 96'(blocks % 65536));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1);
  end

  initial begin
    int k, e_pre, b0;
    logic [63:0] snap;
`ifdef DCT_PINGPONG_EN
    pp = 1'b1;
`endif
    tick(0, 8'h00, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 1);
    chk("rst_m_valid", 96'(m_valid), 96'(0));
    chk("rst_dct_en", 96'(dct_en), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_block_cnt", 96'(block_cnt), 96'(0));
    chk("rst_dct_in", 96'(dct_in), 96'(0));
    chk("rst_m_data", 96'(m_data), 96'(0));

    // samples 1..8 against a core answering 10*i
    mode = 1'b0;
    for (int i = 1; i <= 8; i++) tick(1, 8'(i), 0, 1, 0);
    drain_all();
    chk("first_coef_latency", 96'(mv0_cyc - t_close), 96'(D + 2));

    // partial block closed by flush, then flush with an empty buffer
    mode = 1'b1;
    tick(1, 8'h80, 0, 1, 0);
    tick(1, 8'h7F, 0, 1, 0);
    tick(1, 8'h05, 0, 1, 0);
    tick(0, 8'h00, 1, 1, 0);
    k = 0;
    while (!dct_en && k < 20) begin tick(0, 8'h00, 0, 1, 0); k++; end
    snap = 64'h0000_0000_0005_7F80;
    chk("pad_dct_in", 96'(dct_in), 96'(snap));
    while (dct_en && k < 40) begin
      tick(0, 8'h00, 0, 1, 0); k++;
      if (dct_en) chk("dct_in_stable", 96'(dct_in), 96'(snap));
    end
    drain_all();
    e_pre = en_cycles;
    tick(0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 6; i++) tick(0, 8'h00, 0, 1, 0);
    chk("flush_empty_no_launch", 96'(en_cycles), 96'(e_pre));

    // m_ready pattern 1,0,0,1 while draining
    for (int i = 0; i < 8; i++) tick(1, 8'($urandom), 0, 1, 0);
    k = 0;
    while ((busy_m || expq.size() > 0) && k < 300) begin
      tick(0, 8'h00, 0, (k % 4 == 0) || (k % 4 == 3), 0);
      k++;
    end
    drain_all();

    // reset pulse while the core is running
    for (int i = 0; i < 8; i++) tick(1, 8'($urandom), 0, 1, 0);
    k = 0;
    while (!dct_en && k < 20) begin tick(0, 8'h00, 0, 1, 0); k++; end
    tick(0, 8'h00, 0, 1, 0);
    chk("in_wait_before_rst", 96'(dct_en), 96'(1));
    tick(0, 8'h00, 0, 1, 1);
    tick(0, 8'h00, 0, 1, 0);
    chk("s_ready_after_rst", 96'(s_ready), 96'(1));
    chk("block_cnt_after_rst", 96'(block_cnt), 96'(0));
    for (int i = 0; i < 10; i++) begin
      tick(0, 8'h00, 0, 1, 0);
      chk("rst_no_m_valid", 96'(m_valid), 96'(0));
    end
    for (int i = 0; i < 8; i++) tick(1, 8'($urandom), 0, 1, 0);
    drain_all();

    // s_valid held high across a whole block
    b0 = blocks;
    k = 0;
    while (blocks == b0 && k < 100) begin tick(1, 8'($urandom), 0, 1, 0); k++; end
    tick(1, 8'($urandom), 0, 1, 0);
    tick(0, 8'h00, 1, 1, 0);
    drain_all();
`ifndef DCT_PINGPONG_EN
    chk("no_accept_while_busy", 96'(acc_busy), 96'(0));
`endif

    // randomized blocks with gaps, flushes and backpressure
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) tick($urandom_range(0, 3) != 0, 8'($urandom), 0, 1'($urandom), 0);
      tick(0, 8'h00, 1, 1'($urandom), 0);
      k = 0;
      while ((busy_m || expq.size() > 0) && k < 300) begin tick(0, 8'h00, 0, 1'($urandom), 0); k++; end
      drain_all();
    end
    chk("wrap_block_cnt", 96'(w_block_cnt), 96'(blocks % 4));

`ifdef DCT_PINGPONG_EN
    b0 = blocks;
    for (int i = 0; i < 16; i++) begin
      tick(1, 8'($urandom), 0, 1, 0);
      chk("pp_s_ready", 96'(last_sready), 96'(1));
    end
    drain_all();
    chk("pp_two_blocks", 96'(blocks - b0), 96'(2));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dct_block_sequencer.md
Name: dct_block_sequencer

Overview:
Sequencer between the EEG sample stream and the 8-point DCT core (8 x signed 8-bit in, 8 x signed 12-bit out, en/cs controlled). Collects 8 samples into a block, launches the core, waits its fixed latency, captures the 8 coefficients and serializes them with valid/ready toward the RLE encoder. Supports flushing a partial block with zero padding.

Parameters:
DCT_LATENCY, 3, cycles from launch cycle to valid coefficients at dct_coef (>=1)
CNT_W, 16, width of block counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
s_valid  in  1  input sample valid
s_data  in  8  signed EEG sample
s_ready  out  1  sequencer accepts sample
flush  in  1  pulse: close current partial block
dct_in  out  64  packed samples, sample i at [8i+7:8i], i=0 is first received
dct_en  out  1  core enable
dct_cs  out  1  core chip select
dct_coef  in  96  packed core outputs, Z_i at [12i+11:12i]
m_valid  out  1  coefficient valid
m_data  out  12  signed coefficient
m_index  out  3  coefficient index 0..7
m_last  out  1  high with index 7
m_ready  in  1  downstream accepts
busy  out  1  high in any state except FILL with fill count 0
block_cnt  out  CNT_W  completed (fully drained) blocks, wraps

Behaviour:
- Reset: all outputs 0 (s_ready=0 while rst high), fill count 0, state FILL; in-flight block and captured coefs discarded. Reset mid-operation aborts immediately, no partial output.
- States: FILL -> LAUNCH -> WAIT -> DRAIN -> FILL.
- FILL: s_ready=1. Transfer on s_valid&s_ready; sample written to slot fcnt, fcnt++. On 8th transfer go LAUNCH next cycle.
- flush in FILL with fcnt>0 (after counting a same-cycle transfer): slots fcnt..7 set to 0, go LAUNCH. flush with fcnt=0 ignored. flush outside FILL ignored.
- LAUNCH (1 cycle): dct_en=1, dct_cs=1, s_ready=0; WAIT counter loaded to DCT_LATENCY-1.
- WAIT: dct_en=dct_cs=1, dct_in stable; counter decrements; at 0 latch dct_coef into 8x12 capture register, go DRAIN. Capture occurs exactly DCT_LATENCY cycles after LAUNCH cycle.
- dct_in stable from LAUNCH through capture cycle; dct_en/dct_cs low in FILL and DRAIN.
- DRAIN: m_valid=1, m_data=coef[idx], m_index=idx, m_last=(idx==7). idx advances on m_valid&m_ready; m_data/m_index held while m_ready=0. Transfer with idx=7: block_cnt++ (wraps at 2^CNT_W), fcnt=0, go FILL.
- Latency (m_ready=1): 8th sample accepted cycle T -> LAUNCH T+1 -> capture T+1+DCT_LATENCY -> index 0 at T+2+DCT_LATENCY, index 7 at T+9+DCT_LATENCY; s_ready high again T+10+DCT_LATENCY.
- No arithmetic on data; widths pass through unchanged, sign preserved.

Optional Feature:
Macro DCT_PINGPONG_EN. Defined: second 8-sample input buffer; s_ready stays 1 during LAUNCH/WAIT/DRAIN while the alternate buffer fills; a full (or flushed) alternate buffer launches on the cycle after DRAIN ends, skipping FILL; flush applies to the filling buffer in any state; s_ready=0 only when alternate buffer full and active block not finished. Undefined: single buffer, s_ready=0 outside FILL as above.

Test Plan:
- Samples 1,2,...,8, core model outputs Z_i=10*i, m_ready=1 -> m_data 0,10,...,70 with m_index 0..7, m_last only on 70, first m_valid 5 cycles after 8th accept (DCT_LATENCY=3), block_cnt=1.
- 3 samples (-128,127,5) then flush -> dct_in = {0,0,0,0,0,5,127,-128} (slot 7..0), full 8-coef drain; flush with fcnt=0 -> no dct_en pulse.
- m_ready toggling 1,0,0,1 during DRAIN -> each coefficient emitted once, values/index held while stalled, no skipped index.
- rst high for 1 cycle during WAIT -> no m_valid, block_cnt=0, s_ready=1 next cycle after rst low, next block processed normally.
- dct_en/dct_cs high exactly 1+DCT_LATENCY cycles per block; s_valid held high during DRAIN -> no samples accepted (pingpong off); block_cnt preset near 0xFFFF wraps to 0.
- DCT_PINGPONG_EN: 16 back-to-back samples with s_valid=1, m_ready=1 -> s_ready never drops in first 16 cycles, two blocks drained in order.
